// File: rtl/module_reg_pkg.sv
// module_reg_pkg: shared op encoding, arithmetic mode constants and control priority decode
package module_reg_pkg;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } op_e;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // CLR beats load, load beats count, and INC with DEC cancel out
    function automatic op_e prio_op(input logic clr, input logic wen, input logic inc, input logic dec);
        return clr ? OP_CLR :
               wen ? OP_LOAD :
               (inc && dec) ? OP_NONE :
               inc ? OP_INC :
               dec ? OP_DEC : OP_NONE;
    endfunction

endpackage

// File: rtl/module_reg_cell.sv
// module_reg_cell: one register with clear/load/increment/decrement and wrap or saturate arithmetic
module module_reg_cell
    import module_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SAT   = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  op_e              op_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] value_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] value_q, value_d;
    logic             at_max, at_min, hold;

    // Next value; at the limits saturating mode holds the value and the strobe flags the event
    always_comb begin
        at_max  = value_q == '1;
        at_min  = value_q == '0;
        hold    = SAT == MODE_SAT;
        ovf_o   = en_i && ((op_i == OP_INC && at_max) || (op_i == OP_DEC && at_min));
        value_d = !en_i ? value_q :
                  op_i == OP_CLR  ? '0 :
                  op_i == OP_LOAD ? data_i :
                  op_i == OP_INC  ? ((at_max && hold) ? value_q : value_q + ONE) :
                  op_i == OP_DEC  ? ((at_min && hold) ? value_q : value_q - ONE) : value_q;
    end

    // Stored value with synchronous clear
    always_ff @(posedge clk) begin
        value_q <= rst ? '0 : value_d;
    end

    assign value_o = value_q;

endmodule

// File: rtl/module_reg_bank.sv
// module_reg_bank: NREG-entry register bank with a shared op port, combinational read port and overflow flag
module module_reg_bank
    import module_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREG  = 4,
    parameter  int SAT   = MODE_WRAP,
    localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic [AW-1:0]    Sel,
    input  logic             CLR,
    input  logic             Wen,
    input  logic             INC,
    input  logic             DEC,
    input  logic [WIDTH-1:0] BusOut,
    input  logic [AW-1:0]    RdSel,
    output logic [WIDTH-1:0] dout,
    output logic             Z,
    output logic             OVF
);

    op_e              op;
    logic             sel_ok;
    logic [NREG-1:0]  en;
    logic [NREG-1:0]  strobe;
    logic [WIDTH-1:0] vals [NREG];
    logic             ovf_q, ovf_d;

    assign op     = prio_op(CLR, Wen, INC, DEC);
    assign sel_ok = int'(Sel) < NREG;

    for (genvar i = 0; i < NREG; i++) begin : g_cell
        assign en[i] = sel_ok && (Sel == AW'(i));
        module_reg_cell #(.WIDTH(WIDTH), .SAT(SAT)) u_cell (
            .clk    (Clk),
            .rst    (RST),
            .op_i   (op),
            .en_i   (en[i]),
            .data_i (BusOut),
            .value_o(vals[i]),
            .ovf_o  (strobe[i])
        );
    end

    // Read mux; an out-of-range select reads as zero
    always_comb begin
        dout = '0;
        for (int k = 0; k < NREG; k++)
            if (RdSel == AW'(k)) dout = vals[k];
        Z = dout == '0;
    end

    // Overflow flag is a one-cycle echo of any cell's strobe, dropped by reset
    always_comb begin
        ovf_d = !RST && (|strobe);
    end

    // Overflow flag register
    always_ff @(posedge Clk) begin
        ovf_q <= ovf_d;
    end

    assign OVF = ovf_q;

endmodule

// File: tb/tb_module_reg_bank.sv
// tb_module_reg_bank: wrap/NREG=3 and saturate/NREG=4 banks driven together against an array model
module tb_module_reg_bank;

    logic       clk = 1'b0;
    logic       rst, clr, wen, inc, dec;
    logic [1:0] sel, rdsel;
    logic [7:0] bus;
    logic [7:0] da, db;
    logic       za, zb, oa, ob;

    int ma [4];
    int mb [4];
    bit ea, eb;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    module_reg_bank #(.WIDTH(8), .NREG(3), .SAT(0)) u_a (
        .Clk(clk), .RST(rst), .Sel(sel), .CLR(clr), .Wen(wen), .INC(inc), .DEC(dec),
        .BusOut(bus), .RdSel(rdsel), .dout(da), .Z(za), .OVF(oa)
    );

    module_reg_bank #(.WIDTH(8), .NREG(4), .SAT(1)) u_b (
        .Clk(clk), .RST(rst), .Sel(sel), .CLR(clr), .Wen(wen), .INC(inc), .DEC(dec),
        .BusOut(bus), .RdSel(rdsel), .dout(db), .Z(zb), .OVF(ob)
    );

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_cmp++;
        if (got !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic upd(inout int m [4], input int n, input bit sat, output bit ov);
        int s;
        s  = int'(sel);
        ov = 1'b0;
        if (rst) begin
            foreach (m[k]) m[k] = 0;
            return;
        end
        if (s >= n) return;
        if (clr) m[s] = 0;
        else if (wen) m[s] = int'(bus);
        else if (inc && !dec) begin
            if (m[s] == 255) begin ov = 1'b1; m[s] = sat ? 255 : 0; end
            else m[s] = m[s] + 1;
        end else if (dec && !inc) begin
            if (m[s] == 0) begin ov = 1'b1; m[s] = sat ? 0 : 255; end
            else m[s] = m[s] - 1;
        end
    endtask

    task automatic cyc(input bit r, input int s, input bit c, input bit w, input bit i, input bit d,
                       input int b, input int rs);
        int xa, xb;
        @(negedge clk);
        rst = r; sel = 2'(s); clr = c; wen = w; inc = i; dec = d; bus = 8'(b); rdsel = 2'(rs);
        #1;
        xa = (rs < 3) ? ma[rs] : 0;
        xb = mb[rs];
        chk("a.dout", 32'(da), xa);
        chk("a.Z", 32'(za), int'(xa == 0));
        chk("a.OVF", 32'(oa), int'(ea));
        chk("b.dout", 32'(db), xb);
        chk("b.Z", 32'(zb), int'(xb == 0));
        chk("b.OVF", 32'(ob), int'(eb));
        upd(ma, 3, 1'b0, ea);
        upd(mb, 4, 1'b1, eb);
    endtask

    initial begin
        rst = 1'b1; sel = 0; clr = 0; wen = 0; inc = 0; dec = 0; bus = 0; rdsel = 0;
        upd(ma, 3, 1'b0, ea);
        upd(mb, 4, 1'b1, eb);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 2, 0, 1, 0, 0, 12, 2);
        cyc(0, 2, 0, 0, 1, 0, 0, 2);
        cyc(0, 2, 0, 0, 0, 0, 5, 2);
        cyc(0, 2, 0, 0, 0, 0, 5, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 3);
        cyc(0, 1, 0, 1, 0, 0, 255, 1);
        cyc(0, 1, 0, 0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1, 0, 1);
        cyc(0, 1, 0, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1, 0, 1);
        cyc(0, 1, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 7, 0);
        cyc(0, 0, 1, 1, 1, 0, 34, 0);
        cyc(0, 0, 0, 1, 1, 0, 34, 0);
        cyc(0, 0, 0, 1, 0, 0, 20, 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 3, 0, 1, 0, 0, 99, 3);
        cyc(0, 3, 0, 0, 1, 0, 0, 3);
        cyc(0, 3, 0, 0, 0, 0, 0, 3);
        cyc(0, 0, 0, 1, 0, 0, 255, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 1500; n++) begin
            int b;
            case ($urandom_range(0, 3))
                0: b = 0;
                1: b = 255;
                2: b = 254;
                default: b = int'($urandom_range(0, 255));
            endcase
            cyc($urandom_range(0, 59) == 0, int'($urandom_range(0, 3)),
                $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0,
                b, int'($urandom_range(0, 3)));
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
